// File: rtl/wb_arbiter_if.sv
// Bundle of the three execution-unit result channels plus the register-file
// write port and pending-destination mask driven by wb_arbiter.
interface wb_arbiter_if #(
   parameter int DATA_W = 32,
   parameter int RD_W   = 5
);
   logic                  alu_valid;
   logic [RD_W-1:0]       alu_rd;
   logic [DATA_W-1:0]     alu_data;
   logic                  alu_ready;

   logic                  mul_valid;
   logic [RD_W-1:0]       mul_rd;
   logic [DATA_W-1:0]     mul_data;
   logic                  mul_ready;

   logic                  lsu_valid;
   logic [RD_W-1:0]       lsu_rd;
   logic [DATA_W-1:0]     lsu_data;
   logic                  lsu_ready;

   logic                  wb_en;
   logic [RD_W-1:0]       wb_rd;
   logic [DATA_W-1:0]     wb_data;
   logic [1:0]            wb_src;
   logic [(1<<RD_W)-1:0]  pend_mask;

   modport master (
      output alu_valid, alu_rd, alu_data,
      output mul_valid, mul_rd, mul_data,
      output lsu_valid, lsu_rd, lsu_data,
      input  alu_ready, mul_ready, lsu_ready,
      input  wb_en, wb_rd, wb_data, wb_src, pend_mask
   );

   modport slave (
      input  alu_valid, alu_rd, alu_data,
      input  mul_valid, mul_rd, mul_data,
      input  lsu_valid, lsu_rd, lsu_data,
      output alu_ready, mul_ready, lsu_ready,
      output wb_en, wb_rd, wb_data, wb_src, pend_mask
   );
endinterface

// File: rtl/wb_arbiter.sv
// Three-source writeback arbiter: per-source result queues drained round-robin,
// one result per cycle, into a registered register-file write port.
module wb_arbiter #(
   parameter int DATA_W = 32,
   parameter int RD_W   = 5,
   parameter int DEPTH  = 2
) (
   input logic         clk,
   input logic         rst,
   wb_arbiter_if.slave bus
);
   localparam int NSRC  = 3;
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int NREG  = 1 << RD_W;

   logic [NSRC-1:0]   w_valid, w_ready, w_push, w_pop, w_nonempty;
   logic [RD_W-1:0]   w_in_rd     [NSRC];
   logic [DATA_W-1:0] w_in_data   [NSRC];
   logic [RD_W-1:0]   w_head_rd   [NSRC];
   logic [DATA_W-1:0] w_head_data [NSRC];

   logic [RD_W-1:0]   r_q_rd   [NSRC][DEPTH];
   logic [DATA_W-1:0] r_q_data [NSRC][DEPTH];
   logic [DEPTH-1:0]  r_q_vld  [NSRC];
   logic [PTR_W-1:0]  r_head   [NSRC];
   logic [PTR_W-1:0]  r_tail   [NSRC];
   logic [CNT_W-1:0]  r_count  [NSRC];

   logic [1:0]        r_rr_ptr;
   logic              r_wb_en;
   logic [RD_W-1:0]   r_wb_rd;
   logic [DATA_W-1:0] r_wb_data;
   logic [1:0]        r_wb_src;

   logic              w_gnt_valid;
   logic [1:0]        w_gnt_idx, w_cand1, w_cand2;
   logic [NREG-1:0]   w_pend;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(DEPTH - 1)) return '0;
      else return p + PTR_W'(1);
   endfunction

   function automatic logic [1:0] rr_inc(input logic [1:0] p);
      return (p >= 2'd2) ? 2'd0 : p + 2'd1;
   endfunction

   assign w_valid      = {bus.lsu_valid, bus.mul_valid, bus.alu_valid};
   assign w_in_rd[0]   = bus.alu_rd;
   assign w_in_rd[1]   = bus.mul_rd;
   assign w_in_rd[2]   = bus.lsu_rd;
   assign w_in_data[0] = bus.alu_data;
   assign w_in_data[1] = bus.mul_data;
   assign w_in_data[2] = bus.lsu_data;

   // Ready comes from registered occupancy only, so a full queue stays
   // not-ready in the cycle it is popped; rd==0 handshakes are dropped.
   for (genvar g = 0; g < NSRC; g++) begin : g_src
      assign w_ready[g]     = (r_count[g] < CNT_W'(DEPTH));
      assign w_nonempty[g]  = (r_count[g] != '0);
      assign w_push[g]      = w_valid[g] & w_ready[g] & (w_in_rd[g] != '0);
      assign w_pop[g]       = w_gnt_valid & (w_gnt_idx == 2'(g));
      assign w_head_rd[g]   = r_q_rd[g][r_head[g]];
      assign w_head_data[g] = r_q_data[g][r_head[g]];
   end

   // Round-robin grant: search rr_ptr+1, rr_ptr+2, rr_ptr.
   always_comb begin
      w_cand1     = rr_inc(r_rr_ptr);
      w_cand2     = rr_inc(w_cand1);
      w_gnt_valid = 1'b0;
      w_gnt_idx   = r_rr_ptr;
      if (w_nonempty[w_cand1]) begin
         w_gnt_valid = 1'b1;
         w_gnt_idx   = w_cand1;
      end else if (w_nonempty[w_cand2]) begin
         w_gnt_valid = 1'b1;
         w_gnt_idx   = w_cand2;
      end else if (w_nonempty[r_rr_ptr]) begin
         w_gnt_valid = 1'b1;
         w_gnt_idx   = r_rr_ptr;
      end else begin
         w_gnt_valid = 1'b0;
         w_gnt_idx   = r_rr_ptr;
      end
   end

   // Queue storage, pointers, per-entry valid bits and occupancy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NSRC; i++) begin
            r_head[i]  <= '0;
            r_tail[i]  <= '0;
            r_count[i] <= '0;
            r_q_vld[i] <= '0;
            for (int j = 0; j < DEPTH; j++) begin
               r_q_rd[i][j]   <= '0;
               r_q_data[i][j] <= '0;
            end
         end
      end else begin
         for (int i = 0; i < NSRC; i++) begin
            if (w_push[i]) begin
               r_q_rd[i][r_tail[i]]   <= w_in_rd[i];
               r_q_data[i][r_tail[i]] <= w_in_data[i];
               r_tail[i]              <= ptr_inc(r_tail[i]);
            end
            if (w_pop[i]) begin
               r_head[i] <= ptr_inc(r_head[i]);
            end
            r_q_vld[i] <= (r_q_vld[i] & ~({DEPTH{w_pop[i]}} & (DEPTH'(1) << r_head[i])))
                        | ({DEPTH{w_push[i]}} & (DEPTH'(1) << r_tail[i]));
            case ({w_push[i], w_pop[i]})
               2'b10:   r_count[i] <= r_count[i] + CNT_W'(1);
               2'b01:   r_count[i] <= r_count[i] - CNT_W'(1);
               default: r_count[i] <= r_count[i];
            endcase
         end
      end
   end

   // Writeback stage and round-robin pointer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rr_ptr  <= 2'd2;
         r_wb_en   <= 1'b0;
         r_wb_rd   <= '0;
         r_wb_data <= '0;
         r_wb_src  <= 2'd0;
      end else if (w_gnt_valid) begin
         r_rr_ptr  <= w_gnt_idx;
         r_wb_en   <= 1'b1;
         r_wb_rd   <= w_head_rd[w_gnt_idx];
         r_wb_data <= w_head_data[w_gnt_idx];
         r_wb_src  <= w_gnt_idx;
      end else begin
         r_wb_en   <= 1'b0;
      end
   end

   // Pending mask: every queued destination plus the one in the wb stage.
   always_comb begin
      w_pend = '0;
      for (int i = 0; i < NSRC; i++) begin
         for (int j = 0; j < DEPTH; j++) begin
            w_pend[r_q_rd[i][j]] = w_pend[r_q_rd[i][j]] | r_q_vld[i][j];
         end
      end
      w_pend[r_wb_rd] = w_pend[r_wb_rd] | r_wb_en;
      w_pend[0]       = 1'b0;
   end

   assign bus.alu_ready = w_ready[0];
   assign bus.mul_ready = w_ready[1];
   assign bus.lsu_ready = w_ready[2];
   assign bus.wb_en     = r_wb_en;
   assign bus.wb_rd     = r_wb_rd;
   assign bus.wb_data   = r_wb_data;
   assign bus.wb_src    = r_wb_src;
   assign bus.pend_mask = w_pend;
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: expected writes go into a scoreboard queue,
// a negedge monitor pops and compares each wb_en cycle.
module tb_wb_arbiter;
   typedef struct {
      logic [1:0]  src;
      logic [4:0]  rd;
      logic [31:0] data;
   } wr_t;

   logic clk;
   logic rst;
   int   n_total;
   int   n_pass;
   int   src_cnt [3];
   wr_t  exp_q [$];

   logic [31:0] t2_pend [5] = '{32'hE, 32'hE, 32'hC, 32'h8, 32'h0};
   logic [2:0]  t4_rdy  [8] = '{3'b111, 3'b111, 3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

   wb_arbiter_if #(.DATA_W(32), .RD_W(5)) bus ();

   wb_arbiter #(.DATA_W(32), .RD_W(5), .DEPTH(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.alu_valid = 1'b0; bus.alu_rd = 5'd0; bus.alu_data = 32'd0;
      bus.mul_valid = 1'b0; bus.mul_rd = 5'd0; bus.mul_data = 32'd0;
      bus.lsu_valid = 1'b0; bus.lsu_rd = 5'd0; bus.lsu_data = 32'd0;
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic expect_wr(input logic [1:0] s, input logic [4:0] r, input logic [31:0] d);
      wr_t e;
      e.src = s; e.rd = r; e.data = d;
      exp_q.push_back(e);
   endtask

   // Monitor: every wb_en cycle must match the oldest expected write.
   always @(negedge clk) begin
      if (!rst && bus.wb_en) begin
         if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL wb_unexpected: got rd=%0d data=0x%0h src=%0d, required no write at %0t",
                     bus.wb_rd, bus.wb_data, bus.wb_src, $time);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            chk("wb_src", bus.wb_src, e.src);
            chk("wb_rd", bus.wb_rd, e.rd);
            chk("wb_data", bus.wb_data, e.data);
            if (bus.wb_src < 2'd3) src_cnt[bus.wb_src]++;
         end
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int ia, im, il;
      logic [2:0] vld, rdy;
      n_total = 0;
      n_pass  = 0;
      rst = 1'b1;
      idle();
      tick();
      tick();
      chk("rst_wb_en", bus.wb_en, 1'b0);
      chk("rst_wb_rd", bus.wb_rd, 5'd0);
      chk("rst_wb_data", bus.wb_data, 32'd0);
      chk("rst_wb_src", bus.wb_src, 2'd0);
      chk("rst_pend", bus.pend_mask, 32'd0);
      rst = 1'b0;
      chk("rst_ready", {bus.lsu_ready, bus.mul_ready, bus.alu_ready}, 3'b111);

      // single ALU result
      bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEADBEEF;
      expect_wr(2'd0, 5'd5, 32'hDEADBEEF);
      tick();
      idle();
      chk("t1_pend_acc", bus.pend_mask, 32'h20);
      chk("t1_wben_acc", bus.wb_en, 1'b0);
      tick();
      chk("t1_wben_wb", bus.wb_en, 1'b1);
      chk("t1_pend_wb", bus.pend_mask, 32'h20);
      tick();
      chk("t1_wben_after", bus.wb_en, 1'b0);
      chk("t1_pend_after", bus.pend_mask, 32'h0);

      // three sources in the same edge
      do_reset();
      bus.alu_valid = 1'b1; bus.alu_rd = 5'd1; bus.alu_data = 32'h11;
      bus.mul_valid = 1'b1; bus.mul_rd = 5'd2; bus.mul_data = 32'h22;
      bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd3; bus.lsu_data = 32'h33;
      expect_wr(2'd0, 5'd1, 32'h11);
      expect_wr(2'd1, 5'd2, 32'h22);
      expect_wr(2'd2, 5'd3, 32'h33);
      tick();
      idle();
      for (int i = 0; i < 5; i++) begin
         chk("t2_pend", bus.pend_mask, t2_pend[i]);
         chk("t2_wben", bus.wb_en, (i >= 1 && i <= 3) ? 1'b1 : 1'b0);
         tick();
      end

      // rd==0 is accepted but never written
      bus.mul_valid = 1'b1; bus.mul_rd = 5'd0; bus.mul_data = 32'h5;
      chk("t3_mul_ready", bus.mul_ready, 1'b1);
      tick();
      idle();
      for (int i = 0; i < 3; i++) begin
         chk("t3_pend", bus.pend_mask, 32'h0);
         chk("t3_wben", bus.wb_en, 1'b0);
         chk("t3_mul_ready_after", bus.mul_ready, 1'b1);
         tick();
      end

      // full load: four results from each source
      do_reset();
      src_cnt[0] = 0; src_cnt[1] = 0; src_cnt[2] = 0;
      for (int i = 0; i < 4; i++) begin
         expect_wr(2'd0, 5'(4 + i), 32'hA0000000 + 32'(i));
         expect_wr(2'd1, 5'(8 + i), 32'hB0000000 + 32'(i));
         expect_wr(2'd2, 5'(12 + i), 32'hC0000000 + 32'(i));
      end
      ia = 0; im = 0; il = 0;
      for (int cyc = 0; cyc < 16; cyc++) begin
         bus.alu_valid = (ia < 4); bus.alu_rd = 5'(4 + ia);  bus.alu_data = 32'hA0000000 + 32'(ia);
         bus.mul_valid = (im < 4); bus.mul_rd = 5'(8 + im);  bus.mul_data = 32'hB0000000 + 32'(im);
         bus.lsu_valid = (il < 4); bus.lsu_rd = 5'(12 + il); bus.lsu_data = 32'hC0000000 + 32'(il);
         vld = {bus.lsu_valid, bus.mul_valid, bus.alu_valid};
         rdy = {bus.lsu_ready, bus.mul_ready, bus.alu_ready};
         chk("t4_wben", bus.wb_en, (cyc >= 2 && cyc <= 13) ? 1'b1 : 1'b0);
         if (cyc < 8) chk("t4_ready", rdy, t4_rdy[cyc]);
         tick();
         if (vld[0] & rdy[0]) ia++;
         if (vld[1] & rdy[1]) im++;
         if (vld[2] & rdy[2]) il++;
      end
      idle();
      chk("t4_grants_alu", src_cnt[0], 4);
      chk("t4_grants_mul", src_cnt[1], 4);
      chk("t4_grants_lsu", src_cnt[2], 4);
      chk("t4_drained", exp_q.size(), 0);

      // LSU alone, five results across pointer wrap
      for (int i = 0; i < 5; i++) expect_wr(2'd2, 5'(10 + i), 32'hC0DE0000 + 32'(i));
      il = 0;
      for (int cyc = 0; cyc < 10; cyc++) begin
         bus.lsu_valid = (il < 5); bus.lsu_rd = 5'(10 + il); bus.lsu_data = 32'hC0DE0000 + 32'(il);
         vld = {bus.lsu_valid, 2'b00};
         rdy = {bus.lsu_ready, 2'b00};
         if (cyc < 5) chk("t5_lsu_ready", bus.lsu_ready, 1'b1);
         chk("t5_wben", bus.wb_en, (cyc >= 2 && cyc <= 6) ? 1'b1 : 1'b0);
         tick();
         if (vld[2] & rdy[2]) il++;
      end
      idle();
      chk("t5_drained", exp_q.size(), 0);

      // reset while entries are queued and a write is in flight
      do_reset();
      bus.alu_valid = 1'b1; bus.alu_rd = 5'd16; bus.alu_data = 32'h600;
      bus.mul_valid = 1'b1; bus.mul_rd = 5'd19; bus.mul_data = 32'h603;
      bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd21; bus.lsu_data = 32'h605;
      expect_wr(2'd0, 5'd16, 32'h600);
      expect_wr(2'd1, 5'd19, 32'h603);
      expect_wr(2'd2, 5'd21, 32'h605);
      tick();
      idle();
      bus.alu_valid = 1'b1; bus.alu_rd = 5'd17; bus.alu_data = 32'h601;
      tick();
      bus.alu_rd = 5'd18; bus.alu_data = 32'h602;
      tick();
      idle();
      bus.mul_valid = 1'b1; bus.mul_rd = 5'd20; bus.mul_data = 32'h604;
      tick();
      idle();
      chk("t6_wben_pre", bus.wb_en, 1'b1);
      chk("t6_pend_pre", bus.pend_mask, 32'h0036_0000);
      @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("t6_wben_async", bus.wb_en, 1'b0);
      chk("t6_pend_async", bus.pend_mask, 32'h0);
      tick();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("t6_wben_post", bus.wb_en, 1'b0);
         chk("t6_pend_post", bus.pend_mask, 32'h0);
         tick();
      end
      chk("t6_ready_post", {bus.lsu_ready, bus.mul_ready, bus.alu_ready}, 3'b111);
      chk("final_drained", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
